// File: rtl/uart_tx_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_queue_pkg
//  Description : Shared state encoding and default sizing for uart_tx_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_queue_pkg;

  localparam int TXQ_DEPTH   = 8;
  localparam int TXQ_TIMEOUT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    STROBE    = 3'd2,
    WAIT_BUSY = 3'd3,
    WAIT_DONE = 3'd4
  } txq_state_t;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : byte_fifo
//  Description : Power-of-two circular byte FIFO with same-cycle push/pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH = TXQ_DEPTH
) (
  input  logic                   hz100,
  input  logic                   reset,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   dropped
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;

  logic [7:0]      r_mem [DEPTH];
  logic [c_PW-1:0] r_wrptr;
  logic [c_PW-1:0] r_rdptr;
  logic [c_CW-1:0] r_count;
  logic            w_full;
  logic            w_empty;
  logic            w_pop_ok;
  logic            w_push_ok;

  assign w_full    = (r_count == c_CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop_ok  = pop && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push_ok = push && (!w_full || w_pop_ok);

  assign head    = r_mem[r_rdptr];
  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_count;
  assign dropped = push && !w_push_ok;

  always_ff @(posedge hz100) begin
    if (w_push_ok) begin
      r_mem[r_wrptr] <= push_data;
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      r_wrptr <= '0;
      r_rdptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_wrptr <= r_wrptr + c_PW'(1);
      end
      if (w_pop_ok) begin
        r_rdptr <= r_rdptr + c_PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_queue
//  Description : Byte queue draining into the UART via a txclk/txready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH   = TXQ_DEPTH,
  parameter int TIMEOUT = TXQ_TIMEOUT
) (
  input  logic                   hz100,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             txdata,
  output logic                   txclk,
  input  logic                   txready,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int c_TW = $clog2(TIMEOUT + 1);

  txq_state_t      r_state;
  logic            r_sync1;
  logic            r_rdy_s;
  logic [c_TW-1:0] r_tmo;
  logic [7:0]      r_txdata;
  logic            r_txclk;
  logic            r_busy;
  logic            r_overflow;
  logic            r_timeout_err;
  logic            w_start;
  logic            w_dropped;
  logic [7:0]      w_head;
  logic            w_empty;

  // The head is popped on the edge that enters LOAD, so txdata is settled
  // a full cycle before the strobe.
  assign w_start = (r_state == IDLE) && !w_empty && r_rdy_s;

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .hz100    (hz100),
    .reset    (reset),
    .push     (wr_en),
    .push_data(wr_data),
    .pop      (w_start),
    .head     (w_head),
    .full     (full),
    .empty    (w_empty),
    .count    (count),
    .dropped  (w_dropped)
  );

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_rdy_s <= 1'b0;
    end else begin
      r_sync1 <= txready;
      r_rdy_s <= r_sync1;
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_dropped) begin
      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_tmo         <= '0;
      r_txdata      <= 8'h00;
      r_txclk       <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_txdata <= w_head;
            r_state  <= LOAD;
            r_busy   <= 1'b1;
          end
        end
        LOAD: begin
          r_txclk <= 1'b1;
          r_state <= STROBE;
        end
        STROBE: begin
          r_txclk <= 1'b0;
          r_tmo   <= '0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!r_rdy_s) begin
            r_state <= WAIT_DONE;
          end else if (r_tmo == c_TW'(TIMEOUT - 1)) begin
            // UART never took the byte; give up on it and keep draining.
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
            r_busy        <= 1'b0;
          end else begin
            r_tmo <= r_tmo + c_TW'(1);
          end
        end
        WAIT_DONE: begin
          if (r_rdy_s) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_txclk <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign empty       = w_empty;
  assign overflow    = r_overflow;
  assign txdata      = r_txdata;
  assign txclk       = r_txclk;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_queue
//  Description : Directed bench for uart_tx_queue with a behavioural UART.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

  logic       hz100 = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, txclk, busy, timeout_err;
  logic [3:0] count;
  logic [7:0] txdata;
  logic       txready;

  logic       use_model = 1'b0;
  logic       txready_man = 1'b1;
  logic       mdl_rdy = 1'b1;
  int         low_cycles = 5;

  int         errors = 0;
  int         checks = 0;
  int         nstrobe = 0;
  int         hi_cnt = 0;
  logic [7:0] prev_txd = 8'h00;
  logic [7:0] got [$];

  assign txready = use_model ? mdl_rdy : txready_man;

  always #5 hz100 = ~hz100;

  uart_tx_queue #(.DEPTH(8), .TIMEOUT(16)) dut (
    .hz100      (hz100),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .txdata     (txdata),
    .txclk      (txclk),
    .txready    (txready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor plus UART model: drops txready the cycle after txclk.
  initial begin
    forever begin
      @(negedge hz100);
      if (txclk === 1'b1) begin
        nstrobe++;
        got.push_back(txdata);
        chk("strobe_txdata_setup", {24'd0, txdata}, {24'd0, prev_txd});
        chk("strobe_after_rdy", {31'd0, hi_cnt >= 3}, 32'd1);
        @(negedge hz100);
        chk("strobe_width", {31'd0, txclk}, 32'd0);
        prev_txd = txdata;
        if (use_model) begin
          mdl_rdy = 1'b0;
          hi_cnt  = 0;
          repeat (low_cycles) begin
            @(negedge hz100);
            prev_txd = txdata;
          end
          mdl_rdy = 1'b1;
        end
      end
      prev_txd = txdata;
      hi_cnt   = txready ? hi_cnt + 1 : 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut(input logic model);
    use_model   = model;
    txready_man = 1'b1;
    wr_en       = 1'b0;
    reset       = 1'b1;
    repeat (2) @(negedge hz100);
    reset = 1'b0;
    repeat (4) @(negedge hz100);
  endtask

  task automatic push_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = first + 8'(i);
      @(negedge hz100);
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string name);
    int k = 0;
    while ((got.size() < n || busy) && k < 400) begin
      @(negedge hz100);
      k++;
    end
    chk({name, "_done"}, {31'd0, k < 400}, 32'd1);
    chk({name, "_nbytes"}, got.size(), n);
  endtask

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rdy;
    logic [3:0] count;
    logic       empty;
    logic       full;
    logic       txclk;
    logic       busy;
    logic [7:0] txdata;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int k;
    int s0;

    // Single byte, one vector per cycle, txready driven by hand.
    tbl[0]  = '{1'b1, 8'h41, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41};

    // Reset values
    reset = 1'b1;
    @(negedge hz100);
    chk("rst_txdata", {24'd0, txdata}, 32'h00);
    chk("rst_txclk", {31'd0, txclk}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);

    reset_dut(1'b0);
    got.delete();
    for (int i = 0; i < 12; i++) begin
      wr_en       = tbl[i].wr_en;
      wr_data     = tbl[i].wr_data;
      txready_man = tbl[i].rdy;
      @(negedge hz100);
      chk($sformatf("v%0d_count", i), {28'd0, count}, {28'd0, tbl[i].count});
      chk($sformatf("v%0d_empty", i), {31'd0, empty}, {31'd0, tbl[i].empty});
      chk($sformatf("v%0d_full", i), {31'd0, full}, {31'd0, tbl[i].full});
      chk($sformatf("v%0d_txclk", i), {31'd0, txclk}, {31'd0, tbl[i].txclk});
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("v%0d_txdata", i), {24'd0, txdata}, {24'd0, tbl[i].txdata});
    end
    chk("single_nbytes", got.size(), 1);

    // Order and back-to-back
    low_cycles = 5;
    reset_dut(1'b1);
    got.delete();
    push_seq(8'h10, 3);
    wait_bytes(3, "order");
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk($sformatf("order_byte%0d", i), {24'd0, got[i]}, 32'h10 + i);

    // Full and overflow with txready held low
    reset_dut(1'b0);
    got.delete();
    txready_man = 1'b0;
    repeat (3) @(negedge hz100);
    for (int i = 0; i < 9; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i);
      @(negedge hz100);
      if (i == 7) begin
        chk("full_after8", {31'd0, full}, 32'd1);
        chk("count_after8", {28'd0, count}, 32'd8);
        chk("ovf_after8", {31'd0, overflow}, 32'd0);
      end
    end
    wr_en = 1'b0;
    chk("ovf_after9", {31'd0, overflow}, 32'd1);
    chk("count_after9", {28'd0, count}, 32'd8);
    use_model = 1'b1;
    wait_bytes(8, "fullq");
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("fullq_byte%0d", i), {24'd0, got[i]}, i);
    repeat (30) @(negedge hz100);
    chk("fullq_no_extra", got.size(), 8);
    chk("fullq_empty", {31'd0, empty}, 32'd1);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Wrap-around
    low_cycles = 3;
    reset_dut(1'b1);
    got.delete();
    push_seq(8'h20, 6);
    wait_bytes(6, "wrap1");
    push_seq(8'h30, 6);
    wait_bytes(12, "wrap2");
    for (int i = 0; i < 12 && i < got.size(); i++)
      chk($sformatf("wrap_byte%0d", i), {24'd0, got[i]},
          (i < 6) ? 32'h20 + i : 32'h30 + i - 6);

    // Timeout: txready never falls after the strobe
    reset_dut(1'b0);
    got.delete();
    push_seq(8'h55, 1);
    k = 0;
    while (txclk !== 1'b1 && k < 50) begin
      @(negedge hz100);
      k++;
    end
    chk("tmo_strobe_seen", {31'd0, k < 50}, 32'd1);
    repeat (16) @(negedge hz100);
    chk("tmo_not_yet", {31'd0, timeout_err}, 32'd0);
    chk("tmo_busy_before", {31'd0, busy}, 32'd1);
    @(negedge hz100);
    chk("tmo_set", {31'd0, timeout_err}, 32'd1);
    chk("tmo_idle", {31'd0, busy}, 32'd0);
    use_model = 1'b1;
    push_seq(8'h66, 1);
    wait_bytes(2, "tmo_next");
    if (got.size() == 2) chk("tmo_next_byte", {24'd0, got[1]}, 32'h66);
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);

    // Reset during WAIT_DONE with 3 bytes queued
    low_cycles = 10;
    reset_dut(1'b1);
    got.delete();
    s0 = nstrobe;
    push_seq(8'h70, 4);
    k = 0;
    while (nstrobe == s0 && k < 50) begin
      @(negedge hz100);
      k++;
    end
    chk("rmid_strobe_seen", {31'd0, k < 50}, 32'd1);
    repeat (5) @(negedge hz100);
    chk("rmid_busy_pre", {31'd0, busy}, 32'd1);
    chk("rmid_count_pre", {28'd0, count}, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("rmid_txclk", {31'd0, txclk}, 32'd0);
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_count", {28'd0, count}, 32'd0);
    chk("rmid_empty", {31'd0, empty}, 32'd1);
    chk("rmid_txdata", {24'd0, txdata}, 32'h00);
    s0 = nstrobe;
    repeat (2) @(negedge hz100);
    reset = 1'b0;
    repeat (40) @(negedge hz100);
    chk("rmid_no_strobes", nstrobe, s0);
    got.delete();
    push_seq(8'h7A, 1);
    wait_bytes(1, "rmid_new");
    if (got.size() == 1) chk("rmid_new_byte", {24'd0, got[0]}, 32'h7A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
